// File: rtl/wb_write_arbiter_pkg.sv
// Shared constants and the write-back request type used by the ALU channel,
// the LSU channel and the LSU result FIFO entries.
package wb_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  // One register-file write: destination plus data.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  localparam int WB_REQ_W = $bits(wb_req_t);

endpackage

// File: rtl/wb_write_arbiter_fifo.sv
// Small synchronous FIFO holding LSU results until they win the write slot.
// The head entry is read combinationally so the arbiter can forward it in the
// same cycle it is popped; the write-back register adds the output latency.
module wb_result_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_req_t                push_data,
  input  logic                   pop,
  output wb_req_t                head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_req_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];

  // A push is refused when full even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  // Storage array: no reset, contents are only meaningful below count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port driver: merges single-cycle ALU results with
// buffered LSU results into one registered write per cycle, guards the LSU
// queue against starvation, and tracks pending writes per register.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [REG_ADDR_W-1:0]  issue_rd,
  input  logic                   alu_valid,
  input  logic [REG_ADDR_W-1:0]  alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  output logic                   alu_ready,
  input  logic                   lsu_valid,
  input  logic [REG_ADDR_W-1:0]  lsu_rd,
  input  logic [XLEN-1:0]        lsu_data,
  output logic                   lsu_ready,
  output logic                   reg_write,
  output logic [REG_ADDR_W-1:0]  wb_rd,
  output logic [XLEN-1:0]        wb_data,
  output logic [NUM_REGS-1:0]    busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  wb_req_t                alu_req, lsu_req, head, win_req;
  logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic                   force_fifo, alu_win, win_valid, win_we;
  logic [SW-1:0]          starve_q, starve_d;
  logic                   reg_write_q;
  logic [REG_ADDR_W-1:0]  wb_rd_q;
  logic [XLEN-1:0]        wb_data_q;
  logic [NUM_REGS-1:0]    busy_q, busy_d;

  assign alu_req = '{rd: alu_rd, data: alu_data};
  assign lsu_req = '{rd: lsu_rd, data: lsu_data};

  // x0 loads are accepted but never occupy a FIFO slot.
  assign lsu_ready = !fifo_full;
  assign fifo_push = lsu_valid && lsu_ready && (lsu_rd != '0);

  // The FIFO is forced through once it has lost STARVE_LIMIT times in a row.
  assign force_fifo = (starve_q == SW'(STARVE_LIMIT)) && !fifo_empty;
  assign alu_ready  = !force_fifo;
  assign alu_win    = alu_valid && !force_fifo;
  assign fifo_pop   = !fifo_empty && !alu_win;
  assign win_valid  = alu_win || fifo_pop;
  assign win_req    = alu_win ? alu_req : head;
  assign win_we     = win_valid && (win_req.rd != '0);

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (lsu_req),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Starve counter: counts consecutive ALU wins over a waiting FIFO.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_pop)
      starve_d = '0;
    else if (alu_win && (starve_q != SW'(STARVE_LIMIT)))
      starve_d = starve_q + SW'(1);
  end

  // Per-register pending bits; a new issue beats a same-cycle retirement.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if (gi == 0) begin : g_x0
        assign busy_d[gi] = 1'b0;
      end else begin : g_xn
        assign busy_d[gi] = (issue_valid && (issue_rd == REG_ADDR_W'(gi))) ||
                            (busy_q[gi] && !(reg_write_q && (wb_rd_q == REG_ADDR_W'(gi))));
      end
    end
  endgenerate

  // Write-back register stage, starve counter and scoreboard state.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      starve_q    <= '0;
      busy_q      <= '0;
    end else begin
      reg_write_q <= win_we;
      if (win_we) begin
        wb_rd_q   <= win_req.rd;
        wb_data_q <= win_req.data;
      end
      starve_q    <= starve_d;
      busy_q      <= busy_d;
    end
  end

  assign reg_write = reg_write_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: a queue-based reference model predicts
// each register-file write; a monitor pops predictions as writes appear.
module tb_wb_write_arbiter;
  import wb_write_arbiter_pkg::*;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        lsu_valid = 1'b0;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        lsu_ready;
  logic        reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] busy;
  logic [2:0]  fifo_count;

  wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .reg_write(reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [4:0]  rd;
    bit [31:0] data;
  } req_t;

  // Reference model state
  req_t      mfifo[$];
  req_t      expq[$];
  int        mstarve;
  bit [31:0] mbusy;
  bit        mprev_we;
  bit [4:0]  mprev_rd;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mfifo.delete();
    mstarve  = 0;
    mbusy    = '0;
    mprev_we = 1'b0;
    mprev_rd = '0;
  endtask

  // One clock of stimulus; checks readies/state, then advances the model.
  task automatic cycle(input bit iv, input bit [4:0] ird,
                       input bit av, input bit [4:0] ard, input bit [31:0] ad,
                       input bit lv, input bit [4:0] lrd, input bit [31:0] ld);
    int   size0;
    bit   exp_lr, frc, has_win, popped, alu_won;
    req_t w;
    @(negedge clk);
    rst = 1'b0;
    issue_valid = iv; issue_rd = ird;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    #1;
    size0  = mfifo.size();
    exp_lr = (size0 != DEPTH);
    frc    = (mstarve == STARVE_LIMIT) && (size0 > 0);
    chk("lsu_ready", 64'(lsu_ready), 64'(exp_lr));
    chk("alu_ready", 64'(alu_ready), 64'(!frc));
    chk("fifo_count", 64'(fifo_count), 64'(size0));
    chk("busy", 64'(busy), 64'(mbusy));
    has_win = 0; popped = 0; alu_won = 0;
    w = '{rd: 5'd0, data: 32'd0};
    if (frc || (!av && size0 > 0)) begin
      w = mfifo.pop_front(); has_win = 1; popped = 1;
    end else if (av) begin
      w = '{rd: ard, data: ad}; has_win = 1; alu_won = 1;
    end
    if (lv && exp_lr && lrd != 0) mfifo.push_back('{rd: lrd, data: ld});
    if (size0 == 0 || popped) mstarve = 0;
    else if (alu_won && mstarve < STARVE_LIMIT) mstarve++;
    if (mprev_we) mbusy[mprev_rd] = 1'b0;
    if (iv && ird != 0) mbusy[ird] = 1'b1;
    mprev_we = has_win && (w.rd != 0);
    mprev_rd = w.rd;
    if (mprev_we) expq.push_back(w);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    issue_valid = 0; alu_valid = 0; lsu_valid = 0;
    model_clear();
  endtask

  // Monitor: every DUT write must match the oldest predicted write.
  initial begin
    req_t e;
    forever begin
      @(negedge clk);
      if (reg_write === 1'b1) begin
        if (expq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_write actual rd=%0d data=%0h required=none at %0t",
                   wb_rd, wb_data, $time);
        end else begin
          e = expq.pop_front();
          $display("write rd=%0d data=%08h (expect rd=%0d data=%08h)", wb_rd, wb_data, e.rd, e.data);
          chk("wb_rd", 64'(wb_rd), 64'(e.rd));
          chk("wb_data", 64'(wb_data), 64'(e.data));
        end
      end
    end
  end

  initial begin
    model_clear();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single ALU write
    cycle(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    idle(2);

    // LSU stream with ALU idle
    cycle(0, 0, 0, 0, 0, 1, 3, 32'h11);
    cycle(0, 0, 0, 0, 0, 1, 4, 32'h22);
    cycle(0, 0, 0, 0, 0, 1, 6, 32'h33);
    cycle(0, 0, 0, 0, 0, 1, 7, 32'h44);
    idle(4);

    // Fill FIFO while ALU is busy every cycle, exercising full and starvation
    for (int i = 0; i < 10; i++)
      cycle(0, 0, 1, 5'(10 + i), 32'hA000 + i, 1, 5'(20 + i), 32'hB000 + i);
    for (int i = 0; i < 8; i++)
      cycle(0, 0, 1, 5'(1 + i), 32'hC000 + i, 0, 0, 0);
    idle(5);

    // Scoreboard set/clear interplay on x9
    cycle(1, 9, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 9, 32'h99, 0, 0, 0);
    cycle(1, 9, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 9, 32'h9A, 0, 0, 0);
    idle(3);

    // x0 destinations are dropped
    cycle(1, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 32'h1234);
    cycle(0, 0, 0, 0, 0, 1, 0, 32'h5678);
    idle(2);

    // Reset with entries in flight
    cycle(1, 12, 1, 1, 32'h1, 1, 13, 32'hD1);
    cycle(1, 14, 1, 2, 32'h2, 1, 15, 32'hD2);
    cycle(0, 0, 1, 3, 32'h3, 1, 16, 32'hD3);
    do_reset();
    idle(6);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else
        cycle($urandom_range(0, 99) < 30, 5'($urandom),
              $urandom_range(0, 99) < 60, 5'($urandom), $urandom,
              $urandom_range(0, 99) < 50, 5'($urandom), $urandom);
    end
    idle(12);
    @(negedge clk);
    #2;
    chk("pending_writes", 64'(expq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
